pci_target_device: RTL and testbench

// - 32-bit PCI target (slave) with a small internal word buffer; sits on the shared PCI AD/CBE bus behind a master.
// - Claims memory read/write bursts to its address window; accepts or returns data per-phase via the IRDY/TRDY handshake.
// - Disconnects with STOP when a burst runs past the last buffer location.

---
 rtl/pci_target_device_if.sv | 29 ++
 rtl/pci_target_device.sv | 114 +++++++++++
 tb/tb_pci_target_device.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pci_target_device_if.sv
// Shared PCI AD/CBE bus segment between one initiator and the target.
// The AD net is resolved here: target drive wins, then initiator drive, else released.
// No storage; purely wiring between the two modports.
interface pci_target_device_if;
    logic [31:0] ad_mst_dat;   // initiator AD drive value
    logic        ad_mst_oe;    // initiator AD output enable
    logic [31:0] ad_tgt_dat;   // target AD drive value
    logic        ad_tgt_oe;    // target AD output enable (registered in the target)
    wire  [31:0] AD;           // resolved shared address/data bus
    logic [3:0]  CBEin;
    logic        framein;
    logic        IRDY;
    logic        TRDY;
    logic        DEVSEL;
    logic        stop;

    // Single resolution point for the shared bus so each side only drives its own enable.
    assign AD = ad_tgt_oe ? ad_tgt_dat : (ad_mst_oe ? ad_mst_dat : 32'hzzzz_zzzz);

    modport slave (
        input  AD, CBEin, framein, IRDY,
        output ad_tgt_dat, ad_tgt_oe, TRDY, DEVSEL, stop
    );

    modport master (
        input  AD, ad_tgt_oe, TRDY, DEVSEL, stop,
        output ad_mst_dat, ad_mst_oe, CBEin, framein, IRDY
    );
endinterface

// File: rtl/pci_target_device.sv
// 32-bit PCI memory target with a DEPTH-word buffer, claiming BASE_ADDR..BASE_ADDR+DEPTH-1.
// DEVSEL/TRDY one cycle after the address phase; reads add one turnaround cycle; all outputs registered.
// IRDY high inserts wait states; running past the last word disconnects with STOP (no data moved).
module pci_target_device #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0008,
    parameter int          DEPTH     = 4
) (
    input logic                  clock,
    input logic                  reset,
    pci_target_device_if.slave   bus
);
    localparam int          PW        = $clog2(DEPTH + 1);
    localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(DEPTH) - 32'd1;
    localparam logic [3:0]  CMD_MRD   = 4'b0110;
    localparam logic [3:0]  CMD_MWR   = 4'b0111;

    typedef enum logic [2:0] {IDLE, IGNORE, WRITE, READ_TA, READ, DISCONNECT} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [31:0]    mem_q [DEPTH];
    logic [31:0]    ad_q, ad_d;
    logic           ad_oe_q, ad_oe_d;
    logic           trdy_q, trdy_d;
    logic           devsel_q, devsel_d;
    logic           stop_q, stop_d;
    logic           wr_en;
    logic [PW-1:0]  ptr_inc;
    logic           hit;
    logic           phase_done;

    assign ptr_inc    = ptr_q + 1'b1;
    assign hit        = (bus.AD >= BASE_ADDR) && (bus.AD <= LAST_ADDR);
    assign phase_done = !bus.IRDY && !trdy_q;

    // Next-state decode plus next values of the registered bus outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.framein) begin
                    if (hit && (bus.CBEin == CMD_MWR || bus.CBEin == CMD_MRD)) begin
                        ptr_d   = PW'(bus.AD - BASE_ADDR);
                        state_d = (bus.CBEin == CMD_MWR) ? WRITE : READ_TA;
                    end else begin
                        state_d = IGNORE;
                    end
                end
            end
            IGNORE: begin
                if (bus.framein && bus.IRDY) state_d = IDLE;
            end
            READ_TA: begin
                state_d = (bus.framein && bus.IRDY) ? IDLE : READ;
            end
            WRITE, READ: begin
                if (phase_done) begin
                    wr_en = (state_q == WRITE);
                    ptr_d = ptr_inc;
                    if (bus.framein)                state_d = IDLE;
                    else if (ptr_inc == PW'(DEPTH)) state_d = DISCONNECT;
                end else if (bus.framein && bus.IRDY) begin
                    state_d = IDLE;
                end
            end
            DISCONNECT: begin
                if (bus.framein) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        devsel_d = !(state_d == WRITE || state_d == READ_TA || state_d == READ || state_d == DISCONNECT);
        trdy_d   = !(state_d == WRITE || state_d == READ);
        stop_d   = (state_d != DISCONNECT);
        ad_oe_d  = (state_d == READ);
        ad_d     = mem_q[ptr_d[IW-1:0]];
    end

    // State, pointer, registered outputs and byte-enabled buffer writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            ad_q     <= '0;
            ad_oe_q  <= 1'b0;
            trdy_q   <= 1'b1;
            devsel_q <= 1'b1;
            stop_q   <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ad_q     <= ad_d;
            ad_oe_q  <= ad_oe_d;
            trdy_q   <= trdy_d;
            devsel_q <= devsel_d;
            stop_q   <= stop_d;
            if (wr_en && ptr_q < PW'(DEPTH)) begin
                for (int b = 0; b < 4; b++) begin
                    if (!bus.CBEin[b]) mem_q[ptr_q[IW-1:0]][8*b +: 8] <= bus.AD[8*b +: 8];
                end
            end
        end
    end

    assign bus.ad_tgt_dat = ad_q;
    assign bus.ad_tgt_oe  = ad_oe_q;
    assign bus.TRDY       = trdy_q;
    assign bus.DEVSEL     = devsel_q;
    assign bus.stop       = stop_q;
endmodule

// File: tb/tb_pci_target_device.sv
// Bench for pci_target_device: a PCI initiator model drives bursts; read data is
// checked against a scoreboard of expected words pushed from a byte-enable-aware
// buffer model when each read is issued.
module tb_pci_target_device;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pci_target_device_if pci ();

    pci_target_device #(.BASE_ADDR(32'h0000_0008), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (pci)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [4];
    logic [31:0] exp_q [$];
    logic [31:0] ph_dat [8];
    logic [3:0]  ph_be  [8];

    int phases_done, devsel_cycles, trdy_cycles, oe_cycles, stop_cycles, stop_with_trdy;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        pci.framein    = 1'b1;
        pci.IRDY       = 1'b1;
        pci.ad_mst_oe  = 1'b0;
        pci.ad_mst_dat = '0;
        pci.CBEin      = 4'hf;
    endtask

    // Apply write phases to the model: word index = addr-8+k, only in-window, CBE low enables a byte.
    task automatic model_write(input logic [31:0] addr, input int n);
        for (int k = 0; k < n; k++) begin
            int w = int'(addr) - 8 + k;
            if (w >= 0 && w < 4)
                for (int b = 0; b < 4; b++)
                    if (!ph_be[k][b]) mdl[w][8*b +: 8] = ph_dat[k][8*b +: 8];
        end
    endtask

    // Initiator burst engine: address phase, n data phases (framein=1 on the last),
    // optional one-cycle IRDY wait before phase wait_at, master gives up after budget cycles.
    task automatic burst(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                         input int wait_at, input int budget);
        int k = 0; int cyc = 0; bit stopped = 0; bit waited = 0; bit is_rd;
        logic [31:0] e;
        is_rd = (cmd == 4'b0110);
        devsel_cycles = 0; trdy_cycles = 0; oe_cycles = 0; stop_cycles = 0; stop_with_trdy = 0;
        pci.framein = 1'b0; pci.IRDY = 1'b1; pci.CBEin = cmd;
        pci.ad_mst_dat = addr; pci.ad_mst_oe = 1'b1;
        tick();
        while (k < n && !stopped && cyc < budget) begin
            pci.ad_mst_oe = !is_rd;
            if (k == wait_at && !waited) begin
                pci.IRDY = 1'b1; pci.framein = 1'b0;
                pci.ad_mst_dat = 32'hdead_beef; pci.CBEin = 4'h0;
            end else begin
                pci.IRDY = 1'b0; pci.framein = (k == n - 1);
                pci.ad_mst_dat = ph_dat[k]; pci.CBEin = ph_be[k];
            end
            #1;
            if (!pci.DEVSEL)  devsel_cycles++;
            if (!pci.TRDY)    trdy_cycles++;
            if (pci.ad_tgt_oe) oe_cycles++;
            if (!pci.stop) begin
                stop_cycles++;
                if (!pci.TRDY) stop_with_trdy++;
                stopped = 1;
            end
            if (pci.IRDY) begin
                waited = 1;
                if (is_rd && !pci.TRDY && exp_q.size() > 0) begin
                    checks++;
                    if (pci.AD !== exp_q[0]) begin
                        errors++;
                        $display("FAIL wait_hold: AD %h required %h", pci.AD, exp_q[0]);
                    end
                end
            end else if (!pci.TRDY) begin
                if (is_rd) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL read_extra: AD %h with empty scoreboard", pci.AD);
                    end else begin
                        e = exp_q.pop_front();
                        if (pci.AD !== e) begin
                            errors++;
                            $display("FAIL read_data: AD %h required %h (phase %0d)", pci.AD, e, k);
                        end
                    end
                end
                k++;
            end
            tick();
            cyc++;
        end
        phases_done = k;
        bus_idle();
        tick();
    endtask

    // Outputs must be back at their idle values.
    task automatic check_released(input string name);
        checks++;
        if (pci.DEVSEL !== 1'b1 || pci.TRDY !== 1'b1 || pci.stop !== 1'b1 || pci.ad_tgt_oe !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: DEVSEL=%b TRDY=%b stop=%b oe=%b required 1 1 1 0",
                     name, pci.DEVSEL, pci.TRDY, pci.stop, pci.ad_tgt_oe);
        end
    endtask

    // Full 4-word read at 8 with expected words taken from the model.
    task automatic read_back(input string name, input int wait_at);
        for (int i = 0; i < 4; i++) exp_q.push_back(mdl[i]);
        burst(32'h8, 4'b0110, 4, wait_at, 20);
        checks++;
        if (phases_done != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_phases: done %0d left %0d required 4 0", name, phases_done, exp_q.size());
        end
        checks++;
        if (devsel_cycles != ((wait_at >= 0) ? 6 : 5) || oe_cycles != ((wait_at >= 0) ? 5 : 4)) begin
            errors++;
            $display("FAIL %s_turnaround: devsel %0d oe %0d", name, devsel_cycles, oe_cycles);
        end
        check_released(name);
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_released("reset");
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        read_back("reset_read", -1);
    endtask

    task automatic test_write_burst();
        ph_dat[0] = 32'hffffffff; ph_be[0] = 4'b1111;
        ph_dat[1] = 32'haaaaaaaa; ph_be[1] = 4'b0011;
        ph_dat[2] = 32'hbbbbbbbb; ph_be[2] = 4'b1110;
        ph_dat[3] = 32'hcccccccc; ph_be[3] = 4'b0111;
        model_write(32'h8, 4);
        burst(32'h8, 4'b0111, 4, -1, 12);
        checks++;
        if (phases_done != 4 || devsel_cycles != 4 || trdy_cycles != 4 || stop_cycles != 0) begin
            errors++;
            $display("FAIL wr_burst: done %0d devsel %0d trdy %0d stop %0d required 4 4 4 0",
                     phases_done, devsel_cycles, trdy_cycles, stop_cycles);
        end
        check_released("wr_burst");
        read_back("wr_burst_read", -1);
    endtask

    task automatic test_buffer_end();
        ph_dat[0] = 32'h55555555; ph_dat[1] = 32'h66666666; ph_dat[2] = 32'h77777777;
        ph_dat[3] = 32'h11111111; ph_dat[4] = 32'h44444444;
        for (int i = 0; i < 5; i++) ph_be[i] = 4'b0000;
        model_write(32'h8, 4);
        burst(32'h8, 4'b0111, 5, -1, 12);
        checks++;
        if (phases_done != 4 || stop_cycles != 1 || stop_with_trdy != 0) begin
            errors++;
            $display("FAIL end_stop: done %0d stop %0d stop_trdy %0d required 4 1 0",
                     phases_done, stop_cycles, stop_with_trdy);
        end
        check_released("end_stop");
        read_back("end_read", -1);
    endtask

    task automatic test_offset_write();
        ph_dat[0] = 32'hcccccccc; ph_dat[1] = 32'h99999999; ph_dat[2] = 32'h55115511;
        ph_dat[3] = 32'h33333333;
        for (int i = 0; i < 4; i++) ph_be[i] = 4'b0000;
        model_write(32'h9, 3);
        burst(32'h9, 4'b0111, 4, -1, 12);
        checks++;
        if (phases_done != 3 || stop_cycles != 1) begin
            errors++;
            $display("FAIL offset_stop: done %0d stop %0d required 3 1", phases_done, stop_cycles);
        end
        check_released("offset");
        read_back("offset_read", -1);
    endtask

    task automatic test_wait_states();
        ph_dat[0] = 32'h0badf00d; ph_be[0] = 4'b0000;
        ph_dat[1] = 32'h12345678; ph_be[1] = 4'b1100;
        model_write(32'ha, 2);
        burst(32'ha, 4'b0111, 2, 1, 12);
        checks++;
        if (phases_done != 2 || trdy_cycles != 3) begin
            errors++;
            $display("FAIL wait_write: done %0d trdy %0d required 2 3", phases_done, trdy_cycles);
        end
        read_back("wait_read", 2);
    endtask

    task automatic test_ignore();
        ph_dat[0] = 32'h87654321; ph_be[0] = 4'b0000;
        ph_dat[1] = 32'h13572468; ph_be[1] = 4'b0000;
        burst(32'h0, 4'b0111, 2, -1, 6);
        checks++;
        if (phases_done != 0 || devsel_cycles != 0 || trdy_cycles != 0 || stop_cycles != 0 || oe_cycles != 0) begin
            errors++;
            $display("FAIL ignore: done %0d devsel %0d trdy %0d stop %0d oe %0d required all 0",
                     phases_done, devsel_cycles, trdy_cycles, stop_cycles, oe_cycles);
        end
        burst(32'h9, 4'b0010, 1, -1, 4);
        checks++;
        if (phases_done != 0 || devsel_cycles != 0) begin
            errors++;
            $display("FAIL bad_cmd: done %0d devsel %0d required 0 0", phases_done, devsel_cycles);
        end
        read_back("ignore_read", -1);
    endtask

    task automatic test_reset_abort();
        pci.framein = 1'b0; pci.IRDY = 1'b1; pci.CBEin = 4'b0111;
        pci.ad_mst_dat = 32'h8; pci.ad_mst_oe = 1'b1;
        tick();
        pci.IRDY = 1'b0; pci.CBEin = 4'b0000; pci.ad_mst_dat = 32'h12345678;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_idle();
        check_released("rst_abort");
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        read_back("rst_abort_read", -1);
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_write_burst();
        test_buffer_end();
        test_offset_write();
        test_wait_states();
        test_ignore();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
